lbp_hist: RTL and testbench

Downstream consumer of the LBP engine's output stream. Accumulates a 256-bin histogram of the `lbp_data` codes written during one image pass. On `finish`, it streams all 256 bin counts out over a valid/ready interface for feature extraction. Sits directly on the `lbp_addr`/`lbp_valid`/`lbp_data`/`finish` bus, in parallel with the LBP result memory.

---
 rtl/lbp_pkg.sv | 35 +++
 rtl/lbp_hist_bank.sv | 37 +++
 rtl/lbp_hist.sv | 119 +++++++++++
 tb/tb_lbp_hist.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// lbp_pkg -- shared constants, types and state encoding for the LBP histogram block.
// Rev 1.0
`default_nettype none

package lbp_pkg;

  localparam int IMG_W     = 128;
  localparam int NBINS     = 256;
  localparam int BORDER_LO = 1;
  localparam int BORDER_HI = 126;

  typedef logic [7:0]  lbp_code_t;
  typedef logic [13:0] pix_addr_t;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } hist_state_e;

  // Address is {row, col}; only pixels with a full 3x3 neighbourhood carry a valid code.
  function automatic logic is_interior(input pix_addr_t addr);
    logic [6:0] row;
    logic [6:0] col;
    row = addr[13:7];
    col = addr[6:0];
    return (row >= 7'(BORDER_LO)) && (row <= 7'(BORDER_HI)) &&
           (col >= 7'(BORDER_LO)) && (col <= 7'(BORDER_HI));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lbp_hist_bank.sv
// lbp_hist_bank -- 256 x CNT_W bin storage: clear port, saturating increment, forwarded read.
// Rev 1.0
`default_nettype none

module lbp_hist_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             clr_en,
  input  logic [7:0]       clr_addr,
  input  logic             inc_en,
  input  logic [7:0]       inc_addr,
  input  logic [7:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data
);

  logic [CNT_W-1:0] mem [NBINS];
  logic [CNT_W-1:0] inc_val;

  assign inc_val = (&mem[inc_addr]) ? mem[inc_addr] : mem[inc_addr] + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (inc_en) begin
      mem[inc_addr] <= inc_val;
    end
  end

  // A read of the bin being incremented this cycle sees the post-increment value.
  assign rd_data = (inc_en && (inc_addr == rd_addr)) ? inc_val : mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/lbp_hist.sv
// lbp_hist -- accumulates a 256-bin histogram of LBP codes and streams it out on finish.
// Rev 1.0
`default_nettype none

module lbp_hist
  import lbp_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done,
  output logic [13:0]      pix_total,
  output logic             err
);

  hist_state_e      state;
  logic [7:0]       clr_idx;
  logic             s1_valid;
  logic [7:0]       s1_code;
  logic             interior;
  logic             accept;
  logic             bad_sample;
  logic             xfer;
  logic [7:0]       rd_addr;
  logic [CNT_W-1:0] rd_data;

  assign interior   = is_interior(lbp_addr);
  assign accept     = (state == ST_ACCUM) && lbp_valid && interior;
  assign bad_sample = lbp_valid && ((state != ST_ACCUM) || !interior);
  assign xfer       = (state == ST_DUMP) && hist_valid && hist_ready;
  // Prefetch the bin that will be presented after the next transfer.
  assign rd_addr    = (state == ST_DUMP) ? hist_bin + 8'd1 : 8'd0;

  lbp_hist_bank #(
    .CNT_W (CNT_W)
  ) u_bank (
    .clk      (clk),
    .clr_en   (state == ST_CLEAR),
    .clr_addr (clr_idx),
    .inc_en   (s1_valid),
    .inc_addr (s1_code),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      clr_idx    <= 8'd0;
      s1_valid   <= 1'b0;
      s1_code    <= 8'd0;
      hist_valid <= 1'b0;
      hist_bin   <= 8'd0;
      hist_count <= '0;
      hist_done  <= 1'b0;
      pix_total  <= 14'd0;
      err        <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_code  <= lbp_data;
      if (accept && !(&pix_total)) begin
        pix_total <= pix_total + 14'd1;
      end
      if (bad_sample) begin
        err <= 1'b1;
      end

      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 8'd1;
          if (clr_idx == 8'd255) begin
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (finish) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state      <= ST_DUMP;
          hist_valid <= 1'b1;
          hist_bin   <= 8'd0;
          hist_count <= rd_data;
        end
        ST_DUMP: begin
          if (xfer) begin
            if (hist_bin == 8'hFF) begin
              state      <= ST_DONE;
              hist_valid <= 1'b0;
              hist_done  <= 1'b1;
            end else begin
              hist_bin   <= hist_bin + 8'd1;
              hist_count <= rd_data;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist -- randomized self-checking bench for lbp_hist against a histogram model.
// Rev 1.0
`default_nettype none

module tb_lbp_hist;
  import lbp_pkg::*;

  localparam int CW_M = 14;
  localparam int CW_S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = 14'd0;
  logic [7:0]  lbp_data = 8'd0;
  logic        finish = 1'b0;
  logic        hist_ready = 1'b0;

  logic            m_hv, m_hd, m_err;
  logic [7:0]      m_hb;
  logic [CW_M-1:0] m_hc;
  logic [13:0]     m_pt;
  logic            s_hv, s_hd, s_err;
  logic [7:0]      s_hb;
  logic [CW_S-1:0] s_hc;
  logic [13:0]     s_pt;

  lbp_hist #(.CNT_W(CW_M)) dut_m (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(m_hv), .hist_ready(hist_ready),
    .hist_bin(m_hb), .hist_count(m_hc), .hist_done(m_hd), .pix_total(m_pt), .err(m_err)
  );

  lbp_hist #(.CNT_W(CW_S)) dut_s (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .hist_valid(s_hv), .hist_ready(hist_ready),
    .hist_bin(s_hb), .hist_count(s_hc), .hist_done(s_hd), .pix_total(s_pt), .err(s_err)
  );

  always #5 clk = ~clk;

  int   model [NBINS];
  int   pix_m;
  logic err_m;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic inside_img(input logic [13:0] a);
    int row;
    int col;
    row = int'(a[13:7]);
    col = int'(a[6:0]);
    return (row >= 1) && (row <= 126) && (col >= 1) && (col <= 126);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBINS; i++) model[i] = 0;
    pix_m = 0;
    err_m = 1'b0;
  endtask

  task automatic model_add(input logic [13:0] a, input logic [7:0] d);
    if (inside_img(a)) begin
      model[d]++;
      if (pix_m < 16383) pix_m++;
    end else begin
      err_m = 1'b1;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, {m_hv, s_hv}, 0);
    check_eq({tag, "_bin"},   {m_hb, s_hb}, 0);
    check_eq({tag, "_count"}, {m_hc, s_hc}, 0);
    check_eq({tag, "_done"},  {m_hd, s_hd}, 0);
    check_eq({tag, "_pix"},   {m_pt, s_pt}, 0);
    check_eq({tag, "_err"},   {m_err, s_err}, 0);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b0;
    repeat (cyc) tick();
    reset = 1'b1;
    model_clear();
    check_idle("reset");
  endtask

  task automatic send(input logic [13:0] a, input logic [7:0] d);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    tick();
    lbp_valid = 1'b0;
    model_add(a, d);
  endtask

  task automatic do_finish(input logic with_s, input logic [13:0] a, input logic [7:0] d);
    if (with_s) begin
      lbp_valid = 1'b1;
      lbp_addr  = a;
      lbp_data  = d;
      model_add(a, d);
    end
    finish = 1'b1;
    tick();
    finish    = 1'b0;
    lbp_valid = 1'b0;
    check_eq("drain_valid_low", m_hv, 0);
    check_eq("pix_total_m", m_pt, pix_m);
    check_eq("pix_total_s", s_pt, pix_m);
    check_eq("err_m", m_err, err_m);
    check_eq("err_s", s_err, err_m);
    tick();
    check_eq("dump_start", {m_hv, s_hv}, 2'b11);
  endtask

  logic [13:0] rand_addr;
  task automatic gen_addr();
    if ($urandom_range(0, 9) == 0) rand_addr = 14'($urandom_range(0, 16383));
    else rand_addr = {7'($urandom_range(1, 126)), 7'($urandom_range(1, 126))};
  endtask

  task automatic dump(input int mode, input int nbins);
    int   idx = 0;
    int   k = 0;
    logic stalled = 1'b0;
    logic rdy;
    logic [7:0]  pb = 8'd0;
    logic [31:0] pc = 32'd0;
    while (idx < nbins && k < 8 * NBINS) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      hist_ready = rdy;
      check_eq("dump_valid", {m_hv, s_hv}, 2'b11);
      check_eq("dump_done_low", {m_hd, s_hd}, 0);
      if (stalled) begin
        check_eq("stall_bin", m_hb, pb);
        check_eq("stall_count", m_hc, pc);
      end
      if (rdy) begin
        check_eq("bin_m", m_hb, idx);
        check_eq("bin_s", s_hb, idx);
        check_eq("count_m", m_hc, sat(model[idx], CW_M));
        check_eq("count_s", s_hc, sat(model[idx], CW_S));
        idx++;
      end
      stalled = !rdy;
      pb = m_hb;
      pc = 32'(m_hc);
      tick();
      k++;
    end
    hist_ready = 1'b0;
    check_eq("dump_transfers", idx, nbins);
    if (nbins == NBINS) begin
      check_eq("done_high", {m_hd, s_hd}, 2'b11);
      check_eq("done_valid_low", {m_hv, s_hv}, 0);
    end
  endtask

  task automatic rand_image(input int n);
    logic [7:0] code = 8'd0;
    for (int i = 0; i < n; i++) begin
      gen_addr();
      case ($urandom_range(0, 3))
        0: code = 8'($urandom_range(0, 255));
        1: code = 8'h00;
        2: code = 8'hFF;
        default: code = code;
      endcase
      send(rand_addr, code);
      repeat ($urandom_range(0, 2)) tick();
    end
    gen_addr();
    do_finish(1'b1, rand_addr, 8'($urandom_range(0, 255)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and clear, then an all-zero dump and a sample after DONE.
    do_reset(2);
    repeat (256) tick();
    check_idle("clear_end");
    do_finish(1'b0, 14'd0, 8'd0);
    dump(0, NBINS);
    lbp_valid = 1'b1;
    lbp_addr  = {7'd10, 7'd10};
    lbp_data  = 8'd7;
    tick();
    lbp_valid = 1'b0;
    check_eq("late_sample_err", {m_err, s_err}, 2'b11);
    check_eq("late_sample_pix", m_pt, 0);
    check_eq("done_held", {m_hd, m_hv}, 2'b10);

    // Uniform image.
    do_reset(2);
    repeat (256) tick();
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        send({7'(r), 7'(c)}, 8'h5A);
        if (r == 1 && c == 1) check_eq("pix_latency", m_pt, 1);
      end
    end
    do_finish(1'b0, 14'd0, 8'd0);
    check_eq("uniform_pix", m_pt, 15876);
    dump(0, NBINS);

    // Saturation on the narrow instance.
    do_reset(2);
    repeat (256) tick();
    for (int i = 0; i < 20; i++) begin
      send({7'($urandom_range(1, 126)), 7'($urandom_range(1, 126))}, 8'd5);
    end
    do_finish(1'b0, 14'd0, 8'd0);
    check_eq("sat_pix", s_pt, 20);
    dump(2, NBINS);

    // Border filter.
    do_reset(2);
    repeat (256) tick();
    send(14'h0000, 8'd3);
    send(14'h3FFF, 8'd3);
    send({7'd127, 7'd5}, 8'd3);
    send({7'd1, 7'd126}, 8'd4);
    do_finish(1'b0, 14'd0, 8'd0);
    check_eq("border_err", m_err, 1);
    dump(0, NBINS);

    // Random image with a sample during CLEAR, dumped under 1,0,0,1 backpressure.
    do_reset(3);
    repeat (100) tick();
    lbp_valid = 1'b1;
    lbp_addr  = {7'd5, 7'd5};
    lbp_data  = 8'd9;
    tick();
    lbp_valid = 1'b0;
    err_m = 1'b1;
    check_eq("clear_sample_err", m_err, 1);
    repeat (155) tick();
    rand_image(800);
    dump(1, NBINS);

    // Random image, random backpressure.
    do_reset(2);
    repeat (256) tick();
    rand_image(600);
    dump(2, NBINS);

    // Reset in the middle of a dump.
    do_reset(2);
    repeat (256) tick();
    rand_image(300);
    dump(2, 100);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_clear();
    check_idle("mid_dump_reset");
    repeat (256) tick();
    do_finish(1'b0, 14'd0, 8'd0);
    dump(0, NBINS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
